dll_lock_ctrl: RTL and testbench

Lock-acquisition and tracking controller for the frequency-multiplying DLL. It sequences the 10-bit delay code of the digitally controlled delay line and drives the 2-bit clock-source select of the delay-line input mux. The delay code is first acquired by a successive-approximation search, then tracked ±1 LSB from a phase-detector lead/lag decision, with lock and unlock detection. The block sits beside the phase/time controller and drives `Q` and `Sel` in place of hard-wired values.

---
 rtl/dll_lock_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_dll_lock_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dll_lock_ctrl.sv
// dll_lock_ctrl: lock-acquisition and tracking controller for the DLL.
// Acquires the delay code by successive approximation, then tracks it
// +/-1 LSB from phase-detector lead/lag decisions with lock/unlock detection.
module dll_lock_ctrl #(
    parameter int CODE_W     = 10,
    parameter int SETTLE     = 4,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic              clk_ext,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic [1:0]        M,
    input  logic [3:0]        N,
    input  logic              pd_valid,
    input  logic              pd_lead,
    output logic [CODE_W-1:0] Q,
    output logic [1:0]        Sel,
    output logic              locked,
    output logic              busy,
    output logic              err
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int BW = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int RW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SAR_SETTLE = 3'd1;
    localparam logic [2:0] ST_SAR_WAIT   = 3'd2;
    localparam logic [2:0] ST_TRK_SETTLE = 3'd3;
    localparam logic [2:0] ST_TRK_WAIT   = 3'd4;

    localparam logic [1:0] SEL_GATE = 2'b10;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_REC  = 2'b00;

    localparam logic [CODE_W-1:0] Q_MID  = {1'b1, {(CODE_W-1){1'b0}}};
    localparam logic [CODE_W-1:0] Q_MAX  = {CODE_W{1'b1}};
    localparam logic [CODE_W-1:0] Q_ONE  = {{(CODE_W-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]     CNT_LD = SW'(SETTLE - 1);
    localparam logic [BW-1:0]     BIT_TOP = BW'(CODE_W - 1);
    localparam logic [RW-1:0]     REV_LOCK = RW'(LOCK_CNT);
    localparam logic [UW-1:0]     SAME_UNLOCK = UW'(UNLOCK_CNT);

    logic [2:0]        state, state_nxt;
    logic [CODE_W-1:0] q_nxt;
    logic [1:0]        sel_nxt;
    logic              locked_nxt, err_nxt;
    logic [BW-1:0]     bit_idx, bit_nxt;
    logic [SW-1:0]     cnt, cnt_nxt;
    logic [RW-1:0]     rev, rev_nxt;
    logic [UW-1:0]     same, same_nxt;
    logic              prev_dir, prev_nxt;
    logic              have_prev, have_nxt;
    logic [1:0]        sh_m, sh_m_nxt;
    logic [3:0]        sh_n, sh_n_nxt;
    logic              cfg_chg;
    logic              reversal;
    logic [CODE_W-1:0] bit_mask;

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_nxt  = state;
        q_nxt      = Q;
        sel_nxt    = Sel;
        locked_nxt = locked;
        err_nxt    = err;
        bit_nxt    = bit_idx;
        cnt_nxt    = cnt;
        rev_nxt    = rev;
        same_nxt   = same;
        prev_nxt   = prev_dir;
        have_nxt   = have_prev;
        sh_m_nxt   = sh_m;
        sh_n_nxt   = sh_n;

        cfg_chg  = (M != sh_m) || (N != sh_n);
        reversal = have_prev && (pd_lead != prev_dir);
        bit_mask = Q_ONE << bit_idx;

        if (!en) begin
            state_nxt  = ST_IDLE;
            sel_nxt    = SEL_GATE;
            locked_nxt = 1'b0;
        end else if ((state == ST_IDLE && start) || (state != ST_IDLE && cfg_chg)) begin
            // A config change while busy restarts exactly like a start.
            sh_m_nxt   = M;
            sh_n_nxt   = N;
            q_nxt      = Q_MID;
            bit_nxt    = BIT_TOP;
            err_nxt    = 1'b0;
            sel_nxt    = SEL_EXT;
            locked_nxt = 1'b0;
            cnt_nxt    = CNT_LD;
            rev_nxt    = '0;
            same_nxt   = '0;
            have_nxt   = 1'b0;
            state_nxt  = ST_SAR_SETTLE;
        end else begin
            case (state)
                ST_SAR_SETTLE: begin
                    if (cnt == '0) state_nxt = ST_SAR_WAIT;
                    else           cnt_nxt   = cnt - 1'b1;
                end
                ST_SAR_WAIT: begin
                    if (pd_valid) begin
                        if (!pd_lead) q_nxt = Q & ~bit_mask;
                        cnt_nxt = CNT_LD;
                        if (bit_idx != '0) begin
                            q_nxt     = q_nxt | (bit_mask >> 1);
                            bit_nxt   = bit_idx - 1'b1;
                            state_nxt = ST_SAR_SETTLE;
                        end else begin
                            rev_nxt   = '0;
                            same_nxt  = '0;
                            have_nxt  = 1'b0;
                            state_nxt = ST_TRK_SETTLE;
                        end
                    end
                end
                ST_TRK_SETTLE: begin
                    if (cnt == '0) state_nxt = ST_TRK_WAIT;
                    else           cnt_nxt   = cnt - 1'b1;
                end
                ST_TRK_WAIT: begin
                    if (pd_valid) begin
                        if (pd_lead) begin
                            if (Q == Q_MAX) err_nxt = 1'b1;
                            else            q_nxt   = Q + 1'b1;
                        end else begin
                            if (Q == '0) err_nxt = 1'b1;
                            else         q_nxt   = Q - 1'b1;
                        end
                        if (!reversal)            rev_nxt = '0;
                        else if (rev != REV_LOCK) rev_nxt = rev + 1'b1;
                        if (locked) begin
                            same_nxt = reversal ? '0 : same + 1'b1;
                            if (same_nxt == SAME_UNLOCK) begin
                                locked_nxt = 1'b0;
                                sel_nxt    = SEL_EXT;
                                rev_nxt    = '0;
                                same_nxt   = '0;
                            end
                        end else if (rev_nxt == REV_LOCK) begin
                            locked_nxt = 1'b1;
                            sel_nxt    = SEL_REC;
                            same_nxt   = '0;
                        end
                        prev_nxt  = pd_lead;
                        have_nxt  = 1'b1;
                        cnt_nxt   = CNT_LD;
                        state_nxt = ST_TRK_SETTLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_ext) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            Q         <= Q_MID;
            Sel       <= SEL_GATE;
            locked    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            bit_idx   <= BIT_TOP;
            cnt       <= '0;
            rev       <= '0;
            same      <= '0;
            prev_dir  <= 1'b0;
            have_prev <= 1'b0;
            sh_m      <= '0;
            sh_n      <= '0;
        end else begin
            state     <= state_nxt;
            Q         <= q_nxt;
            Sel       <= sel_nxt;
            locked    <= locked_nxt;
            busy      <= (state_nxt != ST_IDLE);
            err       <= err_nxt;
            bit_idx   <= bit_nxt;
            cnt       <= cnt_nxt;
            rev       <= rev_nxt;
            same      <= same_nxt;
            prev_dir  <= prev_nxt;
            have_prev <= have_nxt;
            sh_m      <= sh_m_nxt;
            sh_n      <= sh_n_nxt;
        end
    end

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// tb_dll_lock_ctrl: directed scenarios plus randomized stimulus, every cycle
// compared against a behavioural model of the lock controller.
module tb_dll_lock_ctrl;

    localparam int CODE_W     = 10;
    localparam int SETTLE     = 4;
    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_CNT = 4;
    localparam int QMAX       = (1 << CODE_W) - 1;

    logic              clk_ext = 1'b0;
    logic              rst_n, en, start, pd_valid, pd_lead;
    logic [1:0]        M;
    logic [3:0]        N;
    logic [CODE_W-1:0] Q;
    logic [1:0]        Sel;
    logic              locked, busy, err;

    // Free-running reference clock.
    always #5 clk_ext = ~clk_ext;

    dll_lock_ctrl #(
        .CODE_W(CODE_W), .SETTLE(SETTLE), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
    ) dut (
        .clk_ext(clk_ext), .rst_n(rst_n), .en(en), .start(start),
        .M(M), .N(N), .pd_valid(pd_valid), .pd_lead(pd_lead),
        .Q(Q), .Sel(Sel), .locked(locked), .busy(busy), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: phase 0 = idle, 1 = acquiring, 2 = tracking.
    int m_q, m_sel, m_locked, m_busy, m_err;
    int m_phase, m_wait, m_bit, m_shm, m_shn;
    int m_prev, m_have, m_rev, m_same;
    bit m_took;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_restart();
        m_shm = int'(M);  m_shn = int'(N);
        m_q = 1 << (CODE_W - 1);
        m_bit = CODE_W - 1;
        m_err = 0;  m_sel = 1;  m_locked = 0;  m_busy = 1;
        m_phase = 1;  m_wait = SETTLE;
    endtask

    task automatic model_step();
        bit rev_now;
        m_took = 0;
        if (!rst_n) begin
            m_q = 1 << (CODE_W - 1);  m_sel = 2;  m_locked = 0;  m_busy = 0;  m_err = 0;
            m_phase = 0;  m_wait = 0;  m_bit = CODE_W - 1;
            m_have = 0;  m_rev = 0;  m_same = 0;
        end else if (!en) begin
            m_phase = 0;  m_sel = 2;  m_locked = 0;  m_busy = 0;
        end else if ((m_phase == 0 && start) ||
                     (m_phase != 0 && (int'(M) != m_shm || int'(N) != m_shn))) begin
            model_restart();
        end else if (m_phase == 0) begin
            // idle holds everything
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (pd_valid) begin
            m_wait = SETTLE;
            if (m_phase == 1) begin
                if (!pd_lead) m_q = m_q & ~(1 << m_bit);
                if (m_bit > 0) begin
                    m_bit = m_bit - 1;
                    m_q = m_q | (1 << m_bit);
                end else begin
                    m_phase = 2;  m_have = 0;  m_rev = 0;  m_same = 0;
                end
            end else begin
                m_took = 1;
                if (pd_lead) begin
                    if (m_q == QMAX) m_err = 1; else m_q++;
                end else begin
                    if (m_q == 0) m_err = 1; else m_q--;
                end
                rev_now = (m_have != 0) && (int'(pd_lead) != m_prev);
                m_rev = rev_now ? m_rev + 1 : 0;
                if (m_locked != 0) begin
                    m_same = rev_now ? 0 : m_same + 1;
                    if (m_same >= UNLOCK_CNT) begin
                        m_locked = 0;  m_sel = 1;  m_rev = 0;  m_same = 0;
                    end
                end else if (m_rev >= LOCK_CNT) begin
                    m_locked = 1;  m_sel = 0;  m_same = 0;
                end
                m_prev = int'(pd_lead);
                m_have = 1;
            end
        end
    endtask

    // One clock: model advances at the edge, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk_ext);
        model_step();
        #1;
        cyc++;
        check("q", 32'(Q), m_q);
        check("sel", 32'(Sel), m_sel);
        check("locked", 32'(locked), m_locked);
        check("busy", 32'(busy), m_busy);
        check("err", 32'(err), m_err);
    endtask

    // Hold one tracking decision until the controller accepts it (bounded).
    task automatic sample(input bit lead);
        bit got_it;
        got_it = 0;
        pd_valid = 1'b1;
        pd_lead  = lead;
        for (int i = 0; i < 20 && !got_it; i++) begin
            tick();
            got_it = m_took;
        end
        check("sample_accepted", 32'(got_it), 1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        int mode;
        rst_n = 1'b0;  en = 1'b0;  start = 1'b0;  pd_valid = 1'b0;  pd_lead = 1'b0;
        M = 2'd1;  N = 4'd3;
        #6;
        tick();  tick();
        check("rst_q", 32'(Q), 32'h200);
        check("rst_sel", 32'(Sel), 2);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;  en = 1'b1;
        tick();

        // SAR convergence onto 346 with pd_valid held high.
        pd_valid = 1'b1;
        pd_lead  = 1'b0;
        do_start();
        k = cyc;
        check("start_q", 32'(Q), 32'h200);
        check("start_busy", 32'(busy), 1);
        for (int i = 0; i < 50; i++) begin
            pd_lead = (m_q <= 346);
            tick();
            if (cyc - k == 49) check("sar_pre_final_q", 32'(Q), 347);
        end
        check("sar_final_q", 32'(Q), 32'h15A);
        check("sar_sel", 32'(Sel), 1);

        // Alternating decisions lock on the 9th tracking sample.
        for (int s = 1; s <= 9; s++) begin
            sample(s % 2 == 1);
            if (s == 8) check("lock_not_yet", 32'(locked), 0);
        end
        check("lock_flag", 32'(locked), 1);
        check("lock_sel", 32'(Sel), 0);
        check("lock_q", 32'(Q), 347);

        // Four same-direction samples drop lock.
        for (int s = 1; s <= 4; s++) begin
            sample(1'b1);
            if (s == 3) check("unlock_not_yet", 32'(locked), 1);
        end
        check("unlock_flag", 32'(locked), 0);
        check("unlock_sel", 32'(Sel), 1);
        check("unlock_q", 32'(Q), 351);

        // start while busy has no effect.
        pd_valid = 1'b0;
        start = 1'b1;
        tick();  tick();
        start = 1'b0;
        check("busy_start_q", 32'(Q), 351);

        // Enable low mid-track: idle, gated select, code held.
        en = 1'b0;
        tick();
        check("en_off_sel", 32'(Sel), 2);
        check("en_off_busy", 32'(busy), 0);
        check("en_off_q", 32'(Q), 351);
        en = 1'b1;
        tick();

        // Saturation at the top end-stop.
        pd_valid = 1'b1;
        pd_lead  = 1'b1;
        do_start();
        for (int i = 0; i < 50; i++) tick();
        check("sat_sar_q", 32'(Q), 32'h3FF);
        sample(1'b1);
        check("sat_q", 32'(Q), 32'h3FF);
        check("sat_err", 32'(err), 1);
        sample(1'b0);
        check("sat_err_sticky", 32'(err), 1);
        en = 1'b0;
        tick();
        check("en_off_err_held", 32'(err), 1);
        en = 1'b1;
        pd_lead = 1'b1;
        do_start();
        check("start_clears_err", 32'(err), 0);

        // Reset in the middle of tracking.
        for (int i = 0; i < 50; i++) tick();
        sample(1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_q", 32'(Q), 32'h200);
        check("rst_mid_sel", 32'(Sel), 2);
        check("rst_mid_locked", 32'(locked), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_err", 32'(err), 0);

        // Config change mid-SAR restarts acquisition.
        pd_valid = 1'b1;
        pd_lead  = 1'b0;
        N = 4'd3;
        do_start();
        for (int i = 0; i < 12; i++) tick();
        check("cfg_pre_q", 32'(Q), 128);
        N = 4'd5;
        tick();
        check("cfg_restart_q", 32'(Q), 32'h200);
        check("cfg_restart_busy", 32'(busy), 1);
        for (int i = 0; i < 50; i++) begin
            pd_lead = (m_q <= 700);
            tick();
        end
        check("cfg_sar_q", 32'(Q), 700);

        // Randomized phase against the model.
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            en    = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 15) == 0);
            if (start) mode = $urandom_range(0, 3);
            if ($urandom_range(0, 499) == 0) N = 4'($urandom);
            if ($urandom_range(0, 499) == 0) M = 2'($urandom);
            pd_valid = ($urandom_range(0, 2) != 0);
            case (mode)
                1:       pd_lead = 1'b1;
                2:       pd_lead = 1'b0;
                3:       pd_lead = 1'($urandom);
                default: pd_lead = ($urandom_range(0, 9) < 8) ? (m_prev == 0) : (m_prev != 0);
            endcase
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
